// File: rtl/spc700_sequencer_pkg.sv
// rtl/spc700_sequencer_pkg.sv - shared constants for the SPC700 instruction sequencer
//
// stateCtrl encodings carried in the microword, plus the opcodes the sequencer
// treats specially (MUL/DIV extension, SLEEP/STOP halt).
package spc700_sequencer_pkg;

    localparam logic [1:0] SC_STEP   = 2'b00;
    localparam logic [1:0] SC_END    = 2'b01;
    localparam logic [1:0] SC_BRCOND = 2'b10;
    localparam logic [1:0] SC_EXTEND = 2'b11;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MUL   = 8'hCF;
    localparam logic [7:0] OP_DIV   = 8'h9E;
    localparam logic [7:0] OP_SLEEP = 8'hEF;
    localparam logic [7:0] OP_STOP  = 8'hFF;

    function automatic logic is_halt_op(input logic [7:0] op);
        return (op == OP_SLEEP) || (op == OP_STOP);
    endfunction

endpackage

// File: rtl/spc700_sequencer.sv
// rtl/spc700_sequencer.sv - SPC700 instruction sequencer producing {IR,STATE} for the microcode ROM
//
// Ports:
//   CLK, RST_N    core clock, synchronous active-low reset
//   EN            clock enable; registers hold when low
//   DI            data bus, latched into IR when an instruction ends
//   STATE_CTRL    stateCtrl field of the current microword
//   BRANCH_TAKEN  condition result used by BRCOND
//   IR, STATE     microcode ROM address; STATE[3] marks MUL/DIV extended cycles
//   LAST_CYCLE    combinational: this enabled cycle ends the instruction
//   ITER          extended-iteration down-counter
//   MULDIV_BUSY   STATE[3]
//   HALTED        SLEEP/STOP executed; only reset releases it
module spc700_sequencer
    import spc700_sequencer_pkg::*;
#(
    parameter int MUL_ITERS = 7,
    parameter int DIV_ITERS = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [7:0] DI,
    input  logic [1:0] STATE_CTRL,
    input  logic       BRANCH_TAKEN,
    output logic [7:0] IR,
    output logic [3:0] STATE,
    output logic       LAST_CYCLE,
    output logic [3:0] ITER,
    output logic       MULDIV_BUSY,
    output logic       HALTED
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_ITERS - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_ITERS - 1);

    logic [7:0] ir_q, ir_d;
    logic [3:0] state_q, state_d;
    logic [3:0] iter_q, iter_d;
    logic [2:0] s_q, s_d;          // normal step at which EXTEND was issued
    logic       halted_q, halted_d;
    logic       ends_instr;
    logic       do_step;
    logic       upd;

    assign upd = EN & ~halted_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ir_q     <= OP_NOP;
            state_q  <= 4'd0;
            iter_q   <= 4'd0;
            s_q      <= 3'd0;
            halted_q <= 1'b0;
        end else if (upd) begin
            ir_q     <= ir_d;
            state_q  <= state_d;
            iter_q   <= iter_d;
            s_q      <= s_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        ir_d       = ir_q;
        state_d    = state_q;
        iter_d     = iter_q;
        s_d        = s_q;
        halted_d   = halted_q;
        ends_instr = 1'b0;
        do_step    = 1'b0;

        if (state_q[3]) begin
            // Extended mode ignores STATE_CTRL; the final extended cycle is
            // flagged with STATE=9 so the microcode can finish the result.
            if (iter_q != 4'd0) begin
                iter_d  = iter_q - 4'd1;
                state_d = {2'b10, (iter_q == 4'd1) ? 2'b01 : 2'b00};
            end else begin
                state_d = {1'b0, s_q + 3'd1};
            end
        end else begin
            case (STATE_CTRL)
                SC_STEP:   do_step = 1'b1;
                SC_END:    ends_instr = 1'b1;
                SC_BRCOND: begin
                    if (BRANCH_TAKEN) do_step = 1'b1;
                    else              ends_instr = 1'b1;
                end
                default: begin
                    if (ir_q == OP_MUL || ir_q == OP_DIV) begin
                        s_d     = state_q[2:0];
                        iter_d  = (ir_q == OP_MUL) ? MUL_LOAD : DIV_LOAD;
                        state_d = 4'b1000;
                    end else begin
                        // Stray EXTEND on an ordinary opcode just advances.
                        do_step = 1'b1;
                    end
                end
            endcase

            if (do_step) begin
                state_d = {1'b0, state_q[2:0] + 3'd1};
            end

            if (ends_instr) begin
                if (is_halt_op(ir_q)) begin
                    halted_d = 1'b1;
                end else begin
                    ir_d    = DI;
                    state_d = 4'd0;
                end
            end
        end
    end

    assign IR          = ir_q;
    assign STATE       = state_q;
    assign ITER        = iter_q;
    assign HALTED      = halted_q;
    assign MULDIV_BUSY = state_q[3];
    assign LAST_CYCLE  = upd & ~state_q[3] & ends_instr;

endmodule

// File: tb/tb_spc700_sequencer.sv
// tb/tb_spc700_sequencer.sv - directed self-checking bench for spc700_sequencer
module tb_spc700_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       EN;
    logic [7:0] DI;
    logic [1:0] STATE_CTRL;
    logic       BRANCH_TAKEN;
    logic [7:0] IR;
    logic [3:0] STATE;
    logic       LAST_CYCLE;
    logic [3:0] ITER;
    logic       MULDIV_BUSY;
    logic       HALTED;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] C_STEP = 2'b00;
    localparam logic [1:0] C_END  = 2'b01;
    localparam logic [1:0] C_BR   = 2'b10;
    localparam logic [1:0] C_EXT  = 2'b11;

    spc700_sequencer #(.MUL_ITERS(7), .DIV_ITERS(10)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .EN           (EN),
        .DI           (DI),
        .STATE_CTRL   (STATE_CTRL),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .IR           (IR),
        .STATE        (STATE),
        .LAST_CYCLE   (LAST_CYCLE),
        .ITER         (ITER),
        .MULDIV_BUSY  (MULDIV_BUSY),
        .HALTED       (HALTED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs shortly after an edge, then settle before comb checks.
    task automatic set_in(input logic rst_n, input logic en, input logic [1:0] ctrl,
                          input logic bt, input logic [7:0] di);
        RST_N = rst_n; EN = en; STATE_CTRL = ctrl; BRANCH_TAKEN = bt; DI = di;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int en_cycles;
    int budget;

    initial begin
        set_in(1'b0, 1'b1, C_END, 1'b0, 8'h00);
        tick(); tick();
        check("rst_ir", IR, 8'h00);
        check("rst_state", STATE, 4'd0);
        check("rst_iter", ITER, 4'd0);
        check("rst_halted", HALTED, 1'b0);
        check("rst_busy", MULDIV_BUSY, 1'b0);

        // 1: NOP ends immediately, fetching E8
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'hE8);
        check("t1_last", LAST_CYCLE, 1'b1);
        tick();
        check("t1_ir", IR, 8'hE8);
        check("t1_state", STATE, 4'd0);

        // 2: STEP, STEP, END
        set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
        check("t2_last_step", LAST_CYCLE, 1'b0);
        tick();
        check("t2_s1", STATE, 4'd1);
        set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
        tick();
        check("t2_s2", STATE, 4'd2);
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'h5D);
        tick();
        check("t2_ir", IR, 8'h5D);
        check("t2_s0", STATE, 4'd0);

        // 3: BRCOND taken then not taken, each at STATE=1
        set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, C_BR, 1'b1, 8'hAA);
        check("t3_last_tk", LAST_CYCLE, 1'b0);
        tick();
        check("t3_tk_state", STATE, 4'd2);
        check("t3_tk_ir", IR, 8'h5D);
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'h5D);
        tick();
        set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, C_BR, 1'b0, 8'hCF);
        check("t3_last_nt", LAST_CYCLE, 1'b1);
        tick();
        check("t3_nt_ir", IR, 8'hCF);
        check("t3_nt_state", STATE, 4'd0);

        // 4: MUL extend at STATE=2; STATE_CTRL held at END to show it is ignored
        set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, C_EXT, 1'b0, 8'h00);
        tick();
        check("t4_busy", MULDIV_BUSY, 1'b1);
        for (int k = 0; k < 7; k++) begin
            set_in(1'b1, 1'b1, C_END, 1'b0, 8'h33);
            check($sformatf("t4_state_%0d", k), STATE, (k < 6) ? 4'd8 : 4'd9);
            check($sformatf("t4_iter_%0d", k), ITER, 4'(6 - k));
            check($sformatf("t4_last_%0d", k), LAST_CYCLE, 1'b0);
            tick();
        end
        check("t4_resume", STATE, 4'd3);
        check("t4_busy_off", MULDIV_BUSY, 1'b0);
        check("t4_ir", IR, 8'hCF);

        // 5: DIV extend at STATE=1 with EN toggling
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'h9E);
        tick();
        set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
        tick();
        set_in(1'b1, 1'b1, C_EXT, 1'b0, 8'h00);
        tick();
        check("t5_iter_load", ITER, 4'd9);
        set_in(1'b1, 1'b0, C_STEP, 1'b0, 8'h00);
        tick();
        check("t5_en0_iter", ITER, 4'd9);
        check("t5_en0_state", STATE, 4'd8);
        en_cycles = 0;
        budget    = 0;
        while (STATE[3] && budget < 60) begin
            set_in(1'b1, budget[0], C_STEP, 1'b0, 8'h00);
            if (EN) en_cycles++;
            tick();
            budget++;
        end
        check("t5_timeout", (budget < 60) ? 1 : 0, 1);
        check("t5_en_cycles", en_cycles, 10);
        check("t5_resume", STATE, 4'd2);

        // STEP wraps 7 -> 0
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'h01);
        tick();
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 1'b1, C_STEP, 1'b0, 8'h00);
            tick();
        end
        check("wrap_state", STATE, 4'd0);
        check("wrap_ir", IR, 8'h01);

        // 6: STOP halts; everything frozen until reset
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'hFF);
        tick();
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'h12);
        check("t6_last", LAST_CYCLE, 1'b1);
        tick();
        check("t6_halted", HALTED, 1'b1);
        check("t6_ir", IR, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1'b1, 2'(k), k[0], 8'(8'h40 + k));
            check($sformatf("t6_last_h%0d", k), LAST_CYCLE, 1'b0);
            tick();
            check($sformatf("t6_ir_h%0d", k), IR, 8'hFF);
            check($sformatf("t6_state_h%0d", k), STATE, 4'd0);
            check($sformatf("t6_halt_h%0d", k), HALTED, 1'b1);
        end
        set_in(1'b0, 1'b0, C_END, 1'b0, 8'h00);
        tick();
        check("t6_rst_ir", IR, 8'h00);
        check("t6_rst_halt", HALTED, 1'b0);

        // 7: reset in the middle of a MUL extend
        set_in(1'b1, 1'b1, C_END, 1'b0, 8'hCF);
        tick();
        set_in(1'b1, 1'b1, C_EXT, 1'b0, 8'h00);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b1, C_END, 1'b0, 8'h00);
            tick();
        end
        check("t7_iter3", ITER, 4'd3);
        set_in(1'b0, 1'b0, C_STEP, 1'b0, 8'h00);
        tick();
        check("t7_state", STATE, 4'd0);
        check("t7_iter", ITER, 4'd0);
        check("t7_busy", MULDIV_BUSY, 1'b0);
        check("t7_ir", IR, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
